im_read_slave: RTL and testbench
================================

IM_READ_SLAVE -- requirements
Module: im_read_slave

Interface
REQ-001 The module SHALL have parameter ID_W, default 8, meaning the slave-side AXI ID width.
REQ-002 The module SHALL have parameter ADDR_W, default 32, meaning the AXI address width.
REQ-003 The module SHALL have parameter DATA_W, default 32, meaning the AXI data and SRAM word width.
REQ-004 The module SHALL have parameter MEM_AW, default 14, meaning the SRAM word-address width (16K words).
REQ-005 The module SHALL have port clk, input, 1 bit: clock, all state on its rising edge.
REQ-006 The module SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have port ARID_S, input, ID_W bits: read-address ID.
REQ-008 The module SHALL have port ARADDR_S, input, ADDR_W bits: byte start address.
REQ-009 The module SHALL have port ARLEN_S, input, 4 bits: burst length minus 1.
REQ-010 The module SHALL have port ARSIZE_S, input, 3 bits: beat size.
REQ-011 The module SHALL have port ARBURST_S, input, 2 bits: burst type.
REQ-012 The module SHALL have ports ARVALID_S (input) and ARREADY_S (output), 1 bit each: AR handshake.
REQ-013 The module SHALL have output RID_S, ID_W bits: returned ID.
REQ-014 The module SHALL have outputs RDATA_S (DATA_W bits), RRESP_S (2 bits) and RLAST_S (1 bit): read beat payload.
REQ-015 The module SHALL have ports RVALID_S (output) and RREADY_S (input), 1 bit each: R handshake.
REQ-016 The module SHALL have outputs mem_cs (1 bit) and mem_addr (MEM_AW bits): SRAM read request.
REQ-017 The module SHALL have input mem_rdata, DATA_W bits: SRAM data, valid exactly one cycle after the mem_cs cycle.

Function
REQ-018 The module SHALL implement the states IDLE, FETCH and DATA.
REQ-019 In IDLE the module SHALL drive ARREADY_S=1; in FETCH and DATA it SHALL drive ARREADY_S=0, so at most one burst is outstanding.
REQ-020 On an AR handshake (ARVALID_S&ARREADY_S) in IDLE, the module SHALL latch ARID_S, ARLEN_S, word index ARADDR_S[MEM_AW+1:2] and an error flag, clear the beat counter, and go to FETCH.
REQ-021 The error flag SHALL be set when ARBURST_S!=2'b01 (INCR) or ARSIZE_S!=3'b010.
REQ-022 In FETCH the module SHALL drive mem_cs=1 and mem_addr=the latched word index, go to DATA the next cycle, and capture mem_rdata into an RDATA register on entry to DATA.
REQ-023 In every state other than FETCH, mem_cs SHALL be 0.
REQ-024 In DATA the module SHALL drive RVALID_S=1, RID_S=latched ID, and RLAST_S=(beat counter==latched ARLEN_S).
REQ-025 In DATA, RDATA_S SHALL be the captured word, or 0 when the error flag is set.
REQ-026 In DATA, RRESP_S SHALL be 2'b00, or 2'b10 (SLVERR) when the error flag is set.
REQ-027 RDATA_S, RRESP_S, RID_S and RLAST_S SHALL stay stable while RVALID_S=1 and RREADY_S=0; RVALID_S SHALL never drop without a handshake.
REQ-028 On an R handshake with RLAST_S=0, the module SHALL increment the word index by 1 modulo 2^MEM_AW, increment the beat counter, and go to FETCH.
REQ-029 On an R handshake with RLAST_S=1, the module SHALL go to IDLE.
REQ-030 Latency SHALL be: AR handshake at edge T gives RVALID_S=1 from T+2; each subsequent beat is valid 2 cycles after the previous R handshake.
REQ-031 An error burst SHALL still return exactly ARLEN_S+1 beats, with RLAST_S on the final beat.
REQ-032 Address bits above MEM_AW+1 and bits [1:0] SHALL be ignored.
REQ-033 ARLEN_S=0 SHALL produce a single beat with RLAST_S=1.

Reset
REQ-034 While rstn=0: state=IDLE; RVALID_S, RLAST_S, mem_cs=0; RID_S, RDATA_S, RRESP_S, mem_addr, counters=0; ARREADY_S=0.
REQ-035 ARREADY_S SHALL assert from the first rising edge after rstn deasserts.
REQ-036 Assertion of rstn mid-burst SHALL abandon the burst immediately, with no further beats after release.

Verification
REQ-037 Single read: ARADDR=0x0000_0010, ARLEN=0, ARID=0x05, RREADY=1 -> mem_addr=4 at T+1; at T+2 RVALID=1, RDATA=mem[4], RID=0x05, RLAST=1, RRESP=00.
REQ-038 Burst: ARADDR=0x100, ARLEN=3 -> four beats of mem[0x40..0x43], RLAST only on the 4th beat.
REQ-039 Backpressure: RREADY=0 for 5 cycles on beat 0 -> RVALID stays 1, RDATA unchanged, no mem_cs pulse until the handshake.
REQ-040 Wrap: word index 0x3FFF, ARLEN=1 -> beats return mem[0x3FFF] then mem[0x0000].
REQ-041 Error: ARBURST=2'b00, ARLEN=2 -> 3 beats, each RDATA=0, RRESP=2'b10, RLAST on the 3rd beat.
REQ-042 Reset mid-burst: rstn low during beat 1 of an ARLEN=3 burst -> all outputs 0 within the same cycle; ARREADY=1 after release; no stale R beats.

Source files
------------

// File: rtl/im_read_slave.sv
// im_read_slave: single-outstanding AXI read slave in front of a synchronous
// single-port SRAM. One SRAM word is fetched per beat; only INCR bursts of
// 32-bit beats are serviced, anything else returns SLVERR beats.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | accepting a new AR request (ARREADY_S=1 once out of reset)
//   FETCH | SRAM read issued for the current word index
//   DATA  | beat presented on R channel, waiting for RREADY_S
module im_read_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ID_W-1:0]   ARID_S,
    input  logic [ADDR_W-1:0] ARADDR_S,
    input  logic [3:0]        ARLEN_S,
    input  logic [2:0]        ARSIZE_S,
    input  logic [1:0]        ARBURST_S,
    input  logic              ARVALID_S,
    output logic              ARREADY_S,
    output logic [ID_W-1:0]   RID_S,
    output logic [DATA_W-1:0] RDATA_S,
    output logic [1:0]        RRESP_S,
    output logic              RLAST_S,
    output logic              RVALID_S,
    input  logic              RREADY_S,
    output logic              mem_cs,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                arready_en_q;
    logic [ID_W-1:0]     id_q;
    logic [3:0]          len_q;
    logic [3:0]          cnt_q;
    logic [MEM_AW-1:0]   widx_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                first_q;
    logic                ar_hs;
    logic                beat_last;
    logic                unused_addr_bits;

    assign ar_hs     = ARVALID_S & ARREADY_S;
    assign beat_last = (cnt_q == len_q);

    // Byte-lane and out-of-range address bits carry no meaning for a word SRAM.
    assign unused_addr_bits = ^{ARADDR_S[ADDR_W-1:MEM_AW+2], ARADDR_S[1:0]};

    // ARREADY must stay low while in reset even though state_q sits in IDLE,
    // so it is gated by a flag that rises on the first edge after release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) arready_en_q <= 1'b0;
        else       arready_en_q <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and per-state handshake/SRAM outputs.
    always_comb begin
        state_d   = state_q;
        ARREADY_S = 1'b0;
        RVALID_S  = 1'b0;
        RLAST_S   = 1'b0;
        RRESP_S   = RESP_OKAY;
        mem_cs    = 1'b0;
        case (state_q)
            IDLE: begin
                ARREADY_S = arready_en_q;
                if (ARVALID_S && arready_en_q) state_d = FETCH;
            end
            FETCH: begin
                mem_cs  = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                RVALID_S = 1'b1;
                RLAST_S  = beat_last;
                RRESP_S  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (RREADY_S) state_d = beat_last ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst bookkeeping: request capture on AR, advance on a non-final R beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q   <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            widx_q <= '0;
            err_q  <= 1'b0;
        end else if (ar_hs) begin
            id_q   <= ARID_S;
            len_q  <= ARLEN_S;
            cnt_q  <= '0;
            widx_q <= ARADDR_S[MEM_AW+1:2];
            err_q  <= (ARBURST_S != BURST_INCR) || (ARSIZE_S != SIZE_WORD);
        end else if (state_q == DATA && RREADY_S && !beat_last) begin
            cnt_q  <= cnt_q + 4'd1;
            widx_q <= widx_q + 1'b1;
        end
    end

    // The SRAM word is valid during the first DATA cycle only; it is shown
    // directly then and held in rdata_q for any backpressured cycles after.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            first_q <= (state_q == FETCH);
            if (first_q) rdata_q <= mem_rdata;
        end
    end

    assign mem_addr = widx_q;
    assign RID_S    = id_q;
    assign RDATA_S  = err_q ? '0 : (first_q ? mem_rdata : rdata_q);

endmodule

// File: tb/tb_im_read_slave.sv
// Bench for im_read_slave: directed AR requests push expected R beats into a
// queue; an independent monitor pops and compares on every R handshake.
module tb_im_read_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S;
    logic        mem_cs;
    logic [13:0] mem_addr;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;
    } beat_t;

    beat_t sb[$];

    im_read_slave #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .MEM_AW(14)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ARID_S    (ARID_S),
        .ARADDR_S  (ARADDR_S),
        .ARLEN_S   (ARLEN_S),
        .ARSIZE_S  (ARSIZE_S),
        .ARBURST_S (ARBURST_S),
        .ARVALID_S (ARVALID_S),
        .ARREADY_S (ARREADY_S),
        .RID_S     (RID_S),
        .RDATA_S   (RDATA_S),
        .RRESP_S   (RRESP_S),
        .RLAST_S   (RLAST_S),
        .RVALID_S  (RVALID_S),
        .RREADY_S  (RREADY_S),
        .mem_cs    (mem_cs),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM contents: a distinct pattern per word index.
    function automatic logic [31:0] word_of(input logic [13:0] idx);
        return {2'b10, idx, 2'b01, ~idx};
    endfunction

    // Synchronous SRAM: data valid the cycle after the mem_cs cycle.
    always @(posedge clk) begin
        if (mem_cs) mem_rdata <= word_of(mem_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every R handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn === 1'b1 && RVALID_S === 1'b1 && RREADY_S === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual data=%0h id=%0h required none", RDATA_S, RID_S);
            end else begin
                beat_t b;
                b = sb.pop_front();
                chk("beat{data,resp,last,id}", {RDATA_S, RRESP_S, RLAST_S, RID_S},
                    {b.data, b.resp, b.last, b.id});
            end
        end
    end

    task automatic push_burst(input logic [7:0] id, input logic [13:0] start,
                              input logic [3:0] len, input logic err);
        for (int i = 0; i <= int'(len); i++) begin
            beat_t b;
            logic [13:0] idx;
            idx    = start + 14'(i);
            b.data = err ? 32'h0 : word_of(idx);
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            b.id   = id;
            sb.push_back(b);
        end
    endtask

    // Issue one AR request; returns 1ns after the handshake edge.
    task automatic ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [1:0] burst, input logic [2:0] size);
        @(posedge clk); #1;
        ARID_S    = id;
        ARADDR_S  = addr;
        ARLEN_S   = len;
        ARBURST_S = burst;
        ARSIZE_S  = size;
        ARVALID_S = 1'b1;
        push_burst(id, addr[15:2], len, (burst != 2'b01) || (size != 3'b010));
        @(negedge clk);
        chk("arready_before_hs", 64'(ARREADY_S), 64'd1);
        @(posedge clk); #1;
        ARVALID_S = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && ARREADY_S === 1'b1) done = 1;
        end
        chk({name, "_completes"}, 64'(done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_seen;
        rstn = 1'b0; ARVALID_S = 0; ARID_S = 0; ARADDR_S = 0; ARLEN_S = 0;
        ARSIZE_S = 3'b010; ARBURST_S = 2'b01; RREADY_S = 1'b1; mem_rdata = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_outputs", {ARREADY_S, RVALID_S, RLAST_S, mem_cs, RID_S, RDATA_S, RRESP_S, mem_addr}, 64'd0);
        rstn = 1'b1;
        #1 chk("arready_before_first_edge", 64'(ARREADY_S), 64'd0);
        @(posedge clk); #1;
        chk("arready_after_first_edge", 64'(ARREADY_S), 64'd1);

        // Single read with latency checks.
        ar(8'h05, 32'h0000_0010, 4'd0, 2'b01, 3'b010);
        chk("single_fetch{cs,addr,rvalid}", {mem_cs, mem_addr, RVALID_S}, {1'b1, 14'd4, 1'b0});
        chk("single_arready_busy", 64'(ARREADY_S), 64'd0);
        @(posedge clk); #1;
        chk("single_rvalid_t2{rvalid,rlast}", {RVALID_S, RLAST_S, mem_cs}, {1'b1, 1'b1, 1'b0});
        wait_idle("single");

        // Four-beat burst.
        ar(8'h11, 32'h0000_0100, 4'd3, 2'b01, 3'b010);
        wait_idle("burst4");

        // Backpressure on beat 0.
        RREADY_S = 1'b0;
        ar(8'h22, 32'h0000_0020, 4'd1, 2'b01, 3'b010);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold{rvalid,rdata,cs,rlast}", {RVALID_S, RDATA_S, mem_cs, RLAST_S},
                {1'b1, word_of(14'd8), 1'b0, 1'b0});
        end
        @(posedge clk); #1;
        RREADY_S = 1'b1;
        wait_idle("backpressure");

        // Wrap at the top of the SRAM; high and low address bits ignored.
        ar(8'h33, 32'hABCD_FFFF, 4'd1, 2'b01, 3'b010);
        wait_idle("wrap");

        // Error bursts: FIXED burst type, then a non-word size.
        ar(8'h44, 32'h0000_0040, 4'd2, 2'b00, 3'b010);
        wait_idle("err_burst");
        ar(8'h55, 32'h0000_0044, 4'd0, 2'b01, 3'b011);
        wait_idle("err_size");

        // Reset during beat 1 of a four-beat burst.
        RREADY_S = 1'b0;
        ar(8'h77, 32'h0000_0200, 4'd3, 2'b01, 3'b010);
        @(posedge clk); #1;
        RREADY_S = 1'b1;
        @(posedge clk); #1;
        RREADY_S = 1'b0;
        @(posedge clk); #1;
        chk("mid_beat1_rvalid", {RVALID_S, RDATA_S}, {1'b1, word_of(14'h81)});
        rstn = 1'b0;
        #1;
        chk("midburst_reset_outputs", {ARREADY_S, RVALID_S, RLAST_S, mem_cs, RID_S, RDATA_S, RRESP_S, mem_addr}, 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        RREADY_S = 1'b1;
        @(posedge clk); #1;
        chk("arready_after_midburst_reset", 64'(ARREADY_S), 64'd1);
        rv_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (RVALID_S !== 1'b0) rv_seen++;
        end
        chk("no_stale_beats", 64'(rv_seen), 64'd0);

        // Normal service after the abandoned burst.
        ar(8'h66, 32'h0000_0008, 4'd0, 2'b01, 3'b010);
        wait_idle("recovery");

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
